// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetches over an imem req/ack handshake, then waits for a
// next-PC decision (sequential, branch, jump, halt). Also counts accepted fetches.
module pc_sequencer #(
    parameter int unsigned       ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              instr_valid,
    input  logic              ctrl_valid,
    input  logic [1:0]        ctrl_sel,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              stall,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    typedef enum logic [1:0] {
        StFetch   = 2'b00,
        StResolve = 2'b01,
        StHalt    = 2'b10
    } state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic              instr_valid_q;
    logic [15:0]       fetch_count_q;

    assign pc_inc = pc_q + ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StFetch;
            pc_q          <= RESET_ADDR;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            instr_valid_q <= 1'b0;
            unique case (state_q)
                StFetch: begin
                    if (imem_ack) begin
                        state_q       <= StResolve;
                        instr_valid_q <= 1'b1;
                        fetch_count_q <= fetch_count_q + 16'd1;
                    end
                end
                StResolve: begin
                    // Stall overrides ctrl_valid; pc only moves on an accepted decision.
                    if (ctrl_valid && !stall) begin
                        unique case (ctrl_sel)
                            2'b00: begin
                                pc_q    <= pc_inc;
                                state_q <= StFetch;
                            end
                            2'b01: begin
                                pc_q    <= branch_taken ? (pc_inc + branch_off) : pc_inc;
                                state_q <= StFetch;
                            end
                            2'b10: begin
                                pc_q    <= jump_addr;
                                state_q <= StFetch;
                            end
                            2'b11: begin
                                state_q <= StHalt;
                            end
                            default: state_q <= StFetch;
                        endcase
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: state_q <= StFetch;
            endcase
        end
    end

    // Request and halt flags are decoded from state alone.
    assign imem_req    = (state_q == StFetch);
    assign halted      = (state_q == StHalt);
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by random stimulus,
// all compared every cycle against a transaction-level reference model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc;
    logic        imem_req;
    logic        imem_ack;
    logic        instr_valid;
    logic        ctrl_valid;
    logic [1:0]  ctrl_sel;
    logic        branch_taken;
    logic [15:0] branch_off;
    logic [15:0] jump_addr;
    logic        stall;
    logic        halted;
    logic [15:0] fetch_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: where the instruction stream stands and what it has produced.
    typedef enum int {AwaitMem, AwaitDecision, Stopped} phase_e;
    phase_e m_phase;
    int     m_pc;
    int     m_cnt;
    bit     m_iv;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W    (16),
        .RESET_ADDR(16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc          (pc),
        .imem_req    (imem_req),
        .imem_ack    (imem_ack),
        .instr_valid (instr_valid),
        .ctrl_valid  (ctrl_valid),
        .ctrl_sel    (ctrl_sel),
        .branch_taken(branch_taken),
        .branch_off  (branch_off),
        .jump_addr   (jump_addr),
        .stall       (stall),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step();
        int so;
        if (rst) begin
            m_phase = AwaitMem;
            m_pc    = 0;
            m_cnt   = 0;
            m_iv    = 0;
            return;
        end
        m_iv = 0;
        case (m_phase)
            AwaitMem: begin
                if (imem_ack) begin
                    m_phase = AwaitDecision;
                    m_iv    = 1;
                    m_cnt   = (m_cnt + 1) % 65536;
                end
            end
            AwaitDecision: begin
                if (ctrl_valid && !stall) begin
                    so = int'(branch_off);
                    if (so >= 32768) so -= 65536;
                    case (ctrl_sel)
                        2'd0: m_pc = (m_pc + 1) % 65536;
                        2'd1: m_pc = (m_pc + 1 + (branch_taken ? so : 0) + 65536) % 65536;
                        2'd2: m_pc = int'(jump_addr);
                        default: ;
                    endcase
                    m_phase = (ctrl_sel == 2'd3) ? Stopped : AwaitMem;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic cycle(input logic r, input logic ack, input logic cv, input logic [1:0] sel,
                         input logic tk, input logic [15:0] off, input logic [15:0] ja,
                         input logic st);
        rst          = r;
        imem_ack     = ack;
        ctrl_valid   = cv;
        ctrl_sel     = sel;
        branch_taken = tk;
        branch_off   = off;
        jump_addr    = ja;
        stall        = st;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("pc", 32'(pc), 32'(m_pc));
        check("imem_req", 32'(imem_req), 32'(m_phase == AwaitMem));
        check("instr_valid", 32'(instr_valid), 32'(m_iv));
        check("halted", 32'(halted), 32'(m_phase == Stopped));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    task automatic seq(input logic ack, input logic cv);
        cycle(1'b0, ack, cv, 2'b00, 1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic decide(input logic [1:0] sel, input logic tk, input logic [15:0] off,
                          input logic [15:0] ja);
        cycle(1'b0, 1'b0, 1'b1, sel, tk, off, ja, 1'b0);
    endtask

    initial begin
        logic [1:0] rsel;
        int         pick;

        // Reset, then continuous sequential fetch.
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 1'b0);
        check("rst_pc", 32'(pc), 32'h0);
        check("rst_req", 32'(imem_req), 32'h1);
        repeat (6) seq(1'b1, 1'b1);
        check("seq_pc", 32'(pc), 32'h3);
        check("seq_cnt", 32'(fetch_count), 32'h3);

        // Slow memory, then a two-cycle stall.
        repeat (3) seq(1'b0, 1'b1);
        check("slow_pc", 32'(pc), 32'h3);
        check("slow_req", 32'(imem_req), 32'h1);
        seq(1'b1, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 16'h0, 16'h0, 1'b1);
        check("stall_pc", 32'(pc), 32'h3);
        seq(1'b0, 1'b1);
        check("unstall_pc", 32'(pc), 32'h4);

        // Branches from 0x0010.
        seq(1'b1, 1'b0);
        decide(2'b10, 1'b0, 16'h0, 16'h0010);
        seq(1'b1, 1'b0);
        decide(2'b01, 1'b1, 16'hFFFC, 16'h0);
        check("br_taken_pc", 32'(pc), 32'h000D);
        seq(1'b1, 1'b0);
        decide(2'b10, 1'b0, 16'h0, 16'h0010);
        seq(1'b1, 1'b0);
        decide(2'b01, 1'b0, 16'hFFFC, 16'h0);
        check("br_not_taken_pc", 32'(pc), 32'h0011);

        // Jump to the top of memory and wrap.
        seq(1'b1, 1'b0);
        decide(2'b10, 1'b0, 16'h0, 16'hFFFF);
        check("jump_pc", 32'(pc), 32'hFFFF);
        seq(1'b1, 1'b0);
        decide(2'b00, 1'b0, 16'h0, 16'h0);
        check("wrap_pc", 32'(pc), 32'h0000);

        // Halt at 0x0005; inputs must be ignored afterwards.
        seq(1'b1, 1'b0);
        decide(2'b10, 1'b0, 16'h0, 16'h0005);
        seq(1'b1, 1'b0);
        decide(2'b11, 1'b0, 16'h0, 16'h0);
        repeat (4) cycle(1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 16'h7, 16'h1234, 1'b0);
        check("halt_pc", 32'(pc), 32'h0005);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_req", 32'(imem_req), 32'h0);

        // Reset out of halt, then reset again in the middle of a resolve.
        cycle(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 16'h0, 1'b0);
        seq(1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 16'h0, 16'h00AA, 1'b0);
        check("mid_rst_pc", 32'(pc), 32'h0);
        check("mid_rst_cnt", 32'(fetch_count), 32'h0);
        check("mid_rst_iv", 32'(instr_valid), 32'h0);
        check("mid_rst_req", 32'(imem_req), 32'h1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            pick = int'($urandom_range(0, 15));
            rsel = (pick < 6) ? 2'b00 : (pick < 11) ? 2'b01 : (pick < 15) ? 2'b10 : 2'b11;
            cycle(($urandom_range(0, 39) == 0), 1'($urandom), 1'($urandom), rsel,
                  1'($urandom), 16'($urandom), 16'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the 16-bit word-addressed program counter and sequences instruction fetch for the single-cycle/multicycle MIPS datapath.
- Drives an instruction-memory request/acknowledge handshake, then waits for the decode/control stage to pick the next PC: sequential (+1), conditional branch, absolute jump, or halt.
- Replaces the free-running "PC + 1" incrementer with a stall-aware controller. It also keeps a count of fetched instructions for debug.

Parameters:
- ADDR_W, 16, PC / address width in words.
- RESET_ADDR, 16'h0000, PC value loaded by reset.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous reset, active-high.
- pc  out  ADDR_W  current fetch address, registered.
- imem_req  out  1  fetch request to instruction memory.
- imem_ack  in  1  memory has returned the instruction at pc.
- instr_valid  out  1  one-cycle pulse: fetched instruction is ready for decode.
- ctrl_valid  in  1  control stage has a next-PC decision.
- ctrl_sel  in  2  decision: 00 sequential, 01 branch, 10 jump, 11 halt.
- branch_taken  in  1  branch condition result; only used when ctrl_sel=01.
- branch_off  in  ADDR_W  signed two's-complement word offset.
- jump_addr  in  ADDR_W  absolute jump target.
- stall  in  1  hazard stall; holds the decision in RESOLVE.
- halted  out  1  high while in HALT.
- fetch_count  out  16  number of accepted fetches, wraps.

Behaviour:
- Synchronous active-high reset, taking priority over everything including mid-fetch or mid-resolve:
  - state=FETCH, pc=RESET_ADDR, fetch_count=0, instr_valid=0, halted=0.
  - imem_req=1 from the first cycle after reset deasserts.
- States: FETCH, RESOLVE, HALT. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- FETCH:
  - imem_req=1 and pc is held stable.
  - On a clock edge with imem_ack=1: go to RESOLVE, set instr_valid=1 for exactly the next cycle, and increment fetch_count (0xFFFF wraps to 0x0000).
  - Without ack, remain in FETCH indefinitely.
  - ctrl_valid and stall are ignored in FETCH.
- RESOLVE:
  - imem_req=0, and imem_ack is ignored.
  - The decision is accepted on an edge where ctrl_valid=1 and stall=0. Otherwise stay in RESOLVE with pc unchanged; stall always overrides ctrl_valid.
  - On accept, next state is FETCH unless halting, with pc updated as:
    - 00: pc+1.
    - 01: pc+1+branch_off if branch_taken=1, else pc+1.
    - 10: jump_addr.
    - 11: pc unchanged, go to HALT.
- HALT: halted=1, imem_req=0, and all inputs are ignored. Only rst exits HALT.
- Arithmetic:
  - Modulo 2^ADDR_W; 0xFFFF+1 = 0x0000.
  - branch_off is sign-interpreted; the result is truncated to ADDR_W with no overflow flag.
- Timing:
  - Minimum of 2 cycles per instruction: ack in the first FETCH cycle, then ctrl_valid in the first RESOLVE cycle.
  - The new pc is visible in the cycle FETCH is re-entered, and imem_req is asserted in that same cycle.
- Handshake:
  - imem_req never drops in FETCH before ack.
  - pc never changes while imem_req=1.

Test Plan:
- Reset then sequential run: rst high 2 cycles, then imem_ack=1 and ctrl_valid=1 with ctrl_sel=00 held continuously → pc sequence 0,1,2,3; instr_valid toggles every other cycle; fetch_count=3 after third ack.
- Slow memory plus stall: ack delayed 3 cycles, then stall=1 for 2 RESOLVE cycles with ctrl_valid=1 → imem_req held high 3 cycles with pc constant; pc unchanged during stall; advances by 1 on the first unstalled cycle.
- Branches at pc=0x0010:
  - ctrl_sel=01, branch_taken=1, branch_off=0xFFFC (−4) → next pc=0x000D.
  - Same with branch_taken=0 → next pc=0x0011.
- Jump and wrap:
  - ctrl_sel=10, jump_addr=0xFFFF → pc=0xFFFF.
  - Then ctrl_sel=00 → pc=0x0000.
- Halt and reset-mid-operation:
  - ctrl_sel=11 at pc=0x0005 → halted=1, imem_req=0, pc stays 0x0005 regardless of ack/ctrl_valid.
  - Assert rst while in RESOLVE on another run → next cycle FETCH, pc=0x0000, fetch_count=0, instr_valid=0.
